// File: rtl/text_loader_pkg.sv
// Shared types and constants for the serial text-memory loader.
package text_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BUF_W  = WORD_W - BYTE_W;
  localparam int unsigned LEN_W  = 16;

  // Frame byte order: length and data words are both little-endian
  localparam int unsigned LEN_LO_SHIFT = 0;
  localparam int unsigned LEN_HI_SHIFT = 8;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_FLUSH,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/text_loader_if.sv
// Byte-stream input and text-memory write port bundled for the loader.
interface text_loader_if
  import text_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) ();

  logic [BYTE_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WORD_W-1:0]     mem_data;
  logic                  mem_write;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_address, mem_data, mem_write
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_address, mem_data, mem_write
  );

endinterface

// File: rtl/text_loader.sv
// Serial program loader: length-prefixed byte frame -> 32-bit text memory writes.
// Define TEXT_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module text_loader
  import text_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  text_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned MAX_WORDS = DEPTH - BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [LEN_W-1:0]        wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]       len_lo_q, len_lo_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic                    in_ready_q, in_ready_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [WORD_W-1:0]       mem_data_q, mem_data_d;
  logic                    mem_write_q, mem_write_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    accept;
  logic [LEN_W-1:0]        len_c;
`ifdef TEXT_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       sum_q, sum_d;
`endif

  assign accept = bus.in_valid && in_ready_q;
  assign len_c  = (LEN_W'(bus.in_data) << LEN_HI_SHIFT) | (LEN_W'(len_lo_q) << LEN_LO_SHIFT);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    addr_d        = addr_q;
    len_lo_d      = len_lo_q;
    buf_d         = buf_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_write_d   = 1'b0;
`ifdef TEXT_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif

    unique case (state_q)
      ST_LEN0: if (accept) begin
        len_lo_d = bus.in_data;
        state_d  = ST_LEN1;
      end
      ST_LEN1: if (accept) begin
        if (len_c == '0 || 32'(len_c) > MAX_WORDS) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_DATA;
          wcnt_d  = len_c;
          addr_d  = BASE;
          idx_d   = 2'd0;
`ifdef TEXT_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_DATA: if (accept) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
        sum_d = sum_q + bus.in_data;
`endif
        idx_d = idx_q + 2'd1;
        unique case (idx_q)
          2'd0: buf_d[7:0]   = bus.in_data;
          2'd1: buf_d[15:8]  = bus.in_data;
          2'd2: buf_d[23:16] = bus.in_data;
          default: begin
            mem_data_d    = {bus.in_data, buf_q};
            mem_address_d = addr_q;
            mem_write_d   = 1'b1;
            wcnt_d        = wcnt_q - LEN_W'(1);
            // Address stops on the last word so it never wraps past the top
            if (wcnt_q == LEN_W'(1)) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_FLUSH;
`endif
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end
        endcase
      end
`ifdef TEXT_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) begin
        state_d = (bus.in_data == sum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    in_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CSUM);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_LEN0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      addr_q        <= BASE;
      len_lo_q      <= '0;
      buf_q         <= '0;
      in_ready_q    <= 1'b0;
      mem_address_q <= BASE;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      cpu_hold_q    <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      addr_q        <= addr_d;
      len_lo_q      <= len_lo_d;
      buf_q         <= buf_d;
      in_ready_q    <= in_ready_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_write_q   <= mem_write_d;
      cpu_hold_q    <= cpu_hold_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

`ifdef TEXT_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_write   = mem_write_q;
  assign cpu_hold        = cpu_hold_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_text_loader.sv
// Scoreboard bench for text_loader: two instances (base 0 and base 0x100).
module tb_text_loader;

  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic [7:0] d_data;
  logic       d_valid;
  bit         d_sel;
  logic       hold0, done0, err0, hold1, done1, err1;

  text_loader_if #(.ADDR_WIDTH(AW)) bus0 ();
  text_loader_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus0.in_data  = d_data;
  assign bus1.in_data  = d_data;
  assign bus0.in_valid = d_valid && !d_sel;
  assign bus1.in_valid = d_valid && d_sel;

  text_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) u_dut0 (
    .clock(clk), .reset_n(rst0_n), .bus(bus0.slave),
    .cpu_hold(hold0), .done(done0), .error(err0)
  );

  text_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h100)) u_dut1 (
    .clock(clk), .reset_n(rst1_n), .bus(bus1.slave),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            gap;
  } wr_t;

  typedef struct {
    string         name;
    bit            sel;
    bit            timeout;
    logic [4:0]    st;     // {done, error, cpu_hold, in_ready, mem_write}
    logic [AW-1:0] addr;
  } st_t;

  wr_t        q0[$];
  wr_t        q1[$];
  st_t        sq[$];
  logic [7:0] txq[$];
  logic [7:0] tx_sum;
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  longint     last0 = 0;
  longint     last1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_wr(input bit sel, input logic [AW-1:0] a, input logic [31:0] d);
    wr_t    e;
    longint gap;
    bit     empty;
    empty = sel ? (q1.size() == 0) : (q0.size() == 0);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL unexpected_write dut%0d addr=%h data=%h required=no write", sel, a, d);
    end else begin
      if (sel) e = q1.pop_front();
      else     e = q0.pop_front();
      if (a !== e.addr || d !== e.data) begin
        failures++;
        $display("FAIL write dut%0d addr=%h data=%h required addr=%h data=%h",
                 sel, a, d, e.addr, e.data);
      end
      if (e.gap != 0) begin
        gap = sel ? (cyc - last1) : (cyc - last0);
        checks++;
        if (gap != longint'(e.gap)) begin
          failures++;
          $display("FAIL write_spacing dut%0d addr=%h gap=%0d required=%0d", sel, a, gap, e.gap);
        end
      end
    end
    if (sel) last1 = cyc;
    else     last0 = cyc;
  endtask

  // Monitor: pops expected writes and status snapshots
  always @(negedge clk) begin
    st_t           s;
    logic [4:0]    act;
    logic [AW-1:0] aa;
    int            pend;
    if (bus0.mem_write) check_wr(1'b0, bus0.mem_address, bus0.mem_data);
    if (bus1.mem_write) check_wr(1'b1, bus1.mem_address, bus1.mem_data);
    if (sq.size() != 0) begin
      s = sq.pop_front();
      checks++;
      if (s.timeout) begin
        failures++;
        $display("FAIL %s timeout waiting on dut%0d required=response", s.name, s.sel);
      end else begin
        act  = s.sel ? {done1, err1, hold1, bus1.in_ready, bus1.mem_write}
                     : {done0, err0, hold0, bus0.in_ready, bus0.mem_write};
        aa   = s.sel ? bus1.mem_address : bus0.mem_address;
        pend = s.sel ? q1.size() : q0.size();
        if (act !== s.st || aa !== s.addr || pend != 0) begin
          failures++;
          $display("FAIL %s {done,error,hold,ready,wr}=%b addr=%h pending=%0d required %b addr=%h pending=0",
                   s.name, act, aa, pend, s.st, s.addr);
        end
      end
    end
  end

  task automatic expect_st(input string name, input bit sel, input logic [4:0] st,
                           input logic [AW-1:0] addr);
    st_t s;
    s.name = name; s.sel = sel; s.timeout = 1'b0; s.st = st; s.addr = addr;
    sq.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic push_timeout(input string name);
    st_t s;
    s.name = name; s.sel = d_sel; s.timeout = 1'b1; s.st = '0; s.addr = '0;
    sq.push_back(s);
  endtask

  function automatic bit cur_ready();
    return d_sel ? bus1.in_ready : bus0.in_ready;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    d_data  = b;
    d_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (cur_ready()) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    push_timeout("send_byte");
  endtask

  task automatic start_frame(input logic [15:0] n);
    txq.delete();
    tx_sum = 8'h00;
    txq.push_back(n[7:0]);
    txq.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      txq.push_back(b);
      tx_sum = tx_sum + b;
    end
  endtask

  task automatic send_txq(input int idle);
    while (txq.size() != 0) begin
      if (idle > 0) begin
        d_valid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
      end
      send_byte(txq.pop_front());
    end
  endtask

  task automatic wait_end(input string name);
    d_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (d_sel ? (done1 | err1) : (done0 | err0)) return;
      @(posedge clk); #1;
    end
    push_timeout(name);
  endtask

  task automatic pulse_reset0();
    d_valid = 1'b0;
    rst0_n  = 1'b0;
    @(posedge clk); #1;
    rst0_n  = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    d_data = 8'h00; d_valid = 1'b0; d_sel = 1'b0;
    rst0_n = 1'b0;  rst1_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    expect_st("reset_dut0", 1'b0, 5'b00100, 14'h0000);
    expect_st("reset_dut1", 1'b1, 5'b00100, 14'h0100);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
    expect_st("ready_dut0", 1'b0, 5'b00110, 14'h0000);

    // N=1 single word at base 0
    d_sel = 1'b0;
    start_frame(16'd1);
    add_word(32'h00000513);
`ifdef TEXT_LOADER_CHECKSUM_EN
    txq.push_back(8'h18);
`endif
    q0.push_back('{addr: 14'h0000, data: 32'h00000513, gap: 0});
    send_txq(0);
    wait_end("n1_end");
    expect_st("n1_done", 1'b0, 5'b10000, 14'h0000);

    // N=3 back-to-back at base 0x100, writes 4 cycles apart
    d_sel = 1'b1;
    start_frame(16'd3);
    add_word(32'h11223344);
    add_word(32'h55667788);
    add_word(32'h99AABBCC);
`ifdef TEXT_LOADER_CHECKSUM_EN
    txq.push_back(tx_sum);
`endif
    q1.push_back('{addr: 14'h0100, data: 32'h11223344, gap: 0});
    q1.push_back('{addr: 14'h0101, data: 32'h55667788, gap: 4});
    q1.push_back('{addr: 14'h0102, data: 32'h99AABBCC, gap: 4});
    send_txq(0);
    wait_end("n3_end");
    expect_st("n3_done", 1'b1, 5'b10000, 14'h0102);

    // Zero length
    d_sel = 1'b0;
    pulse_reset0();
    start_frame(16'd0);
    send_txq(0);
    wait_end("n0_end");
    expect_st("n0_error", 1'b0, 5'b01100, 14'h0000);

`ifdef TEXT_LOADER_CHECKSUM_EN
    // Bad checksum after two good words
    pulse_reset0();
    start_frame(16'd2);
    add_word(32'hCAFEF00D);
    add_word(32'h01020304);
    txq.push_back(tx_sum + 8'h01);
    q0.push_back('{addr: 14'h0000, data: 32'hCAFEF00D, gap: 0});
    q0.push_back('{addr: 14'h0001, data: 32'h01020304, gap: 4});
    send_txq(0);
    wait_end("csum_end");
    expect_st("csum_error", 1'b0, 5'b01100, 14'h0001);
`endif

    // Full memory: N=16384 fills 0..0x3FFF without wrapping
    pulse_reset0();
    start_frame(16'd16384);
    for (int i = 0; i < 16384; i++) begin
      logic [31:0] w;
      w = 32'hA5000000 | 32'(i);
      add_word(w);
      q0.push_back('{addr: AW'(i), data: w, gap: (i == 0) ? 0 : 4});
    end
`ifdef TEXT_LOADER_CHECKSUM_EN
    txq.push_back(tx_sum);
`endif
    send_txq(0);
    wait_end("full_end");
    expect_st("full_done", 1'b0, 5'b10000, 14'h3FFF);

    // One word too many
    pulse_reset0();
    start_frame(16'd16385);
    send_txq(0);
    wait_end("over_end");
    expect_st("over_error", 1'b0, 5'b01100, 14'h0000);

    // Reset mid-word, then a fresh frame with idle gaps
    pulse_reset0();
    start_frame(16'd1);
    txq.push_back(8'hAA);
    txq.push_back(8'hBB);
    send_txq(0);
    d_valid = 1'b0;
    rst0_n  = 1'b0;
    #1;
    expect_st("midreset_hold", 1'b0, 5'b00100, 14'h0000);
    rst0_n = 1'b1;
    @(posedge clk); #1;
    start_frame(16'd1);
    add_word(32'hDEADBEEF);
`ifdef TEXT_LOADER_CHECKSUM_EN
    txq.push_back(tx_sum);
`endif
    q0.push_back('{addr: 14'h0000, data: 32'hDEADBEEF, gap: 0});
    send_txq(1);
    wait_end("fresh_end");
    expect_st("fresh_done", 1'b0, 5'b10000, 14'h0000);

    repeat (3) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
